// File: rtl/axis_skid_fifo.sv
// AXI-Stream style FIFO with a registered output stage; DEPTH entries total including the output register.
// Latency: one cycle from accept into an empty block to m_valid; one beat per cycle when streaming.
// Backpressure: s_ready is registered (level != DEPTH), so it has no combinational path from m_ready or s_valid.
//
// Ports:
//   clk, rst_n            - rising-edge clock, asynchronous active-low reset
//   flush                 - synchronous discard of all stored beats (beats offered on the same edge are dropped)
//   s_valid/s_ready/s_data/s_last - upstream beat interface
//   m_valid/m_ready/m_data/m_last - downstream beat interface, driven straight from flops
//   level, almost_full    - occupancy (0..DEPTH) and level >= AFULL_LEVEL, both registered
module axis_skid_fifo #(
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_last,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    almost_full
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  // Ring buffer holding beats behind the output register. Only DEPTH-1 slots
  // are ever occupied, but a power-of-two ring keeps pointer wrap free.
  beat_t           mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            m_valid_q, m_valid_d;
  beat_t           m_beat_q, m_beat_d;
  logic            s_ready_q, s_ready_d;
  logic            afull_q, afull_d;

  logic            push, pop, mem_we, mem_empty;
  logic [LW-1:0]   mem_cnt;

  always_comb begin
    push      = s_valid && s_ready_q;
    pop       = m_valid_q && m_ready;
    // Beats in the ring = total occupancy minus the one in the output register.
    mem_cnt   = level_q - LW'(m_valid_q);
    mem_empty = (mem_cnt == '0);

    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    level_d   = level_q;
    m_valid_d = m_valid_q;
    m_beat_d  = m_beat_q;
    mem_we    = 1'b0;

    if (flush) begin
      // Flush wins over any same-edge accept or pop; m_data/m_last keep their value.
      level_d   = '0;
      m_valid_d = 1'b0;
      wptr_d    = '0;
      rptr_d    = '0;
    end else begin
      level_d = level_q + LW'(push) - LW'(pop);
      if (!m_valid_q || m_ready) begin
        // Output register is free this edge: refill from the ring head, or
        // bypass the incoming beat straight in when the ring is empty.
        if (!mem_empty) begin
          m_beat_d  = mem_q[rptr_q];
          rptr_d    = rptr_q + PW'(1);
          m_valid_d = 1'b1;
          mem_we    = push;
        end else if (push) begin
          m_beat_d  = '{last: s_last, data: s_data};
          m_valid_d = 1'b1;
        end else begin
          m_valid_d = 1'b0;
        end
      end else begin
        mem_we = push;
      end
    end

    if (mem_we) wptr_d = wptr_q + PW'(1);

    s_ready_d = (level_d != LW'(DEPTH));
    afull_d   = (level_d >= LW'(AFULL_LEVEL));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      m_valid_q <= 1'b0;
      m_beat_q  <= '0;
      // Held low through reset so nothing is accepted before the first edge after release.
      s_ready_q <= 1'b0;
      afull_q   <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      m_valid_q <= m_valid_d;
      m_beat_q  <= m_beat_d;
      s_ready_q <= s_ready_d;
      afull_q   <= afull_d;
    end
  end

  // Storage array carries no reset; occupancy is tracked by level/pointers.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wptr_q] <= '{last: s_last, data: s_data};
  end

  assign s_ready     = s_ready_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_beat_q.data;
  assign m_last      = m_beat_q.last;
  assign level       = level_q;
  assign almost_full = afull_q;

endmodule

// File: tb/tb_axis_skid_fifo.sv
module tb_axis_skid_fifo;

  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int AFULL = DEPTH - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [2:0]    level;
  logic          almost_full;

  int n_vec = 0;
  int n_err = 0;
  int n_pop = 0;
  int n_push = 0;
  bit mon_en = 1'b0;
  logic [DW:0] sb_q[$];

  axis_skid_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .level(level), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW:0] act, input logic [DW:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Outputs are checked 1 time unit after the edge; inputs change there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: samples handshakes mid-cycle, before the edge that commits them.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else if (mon_en) begin
      chk("mon_level", level, sb_q.size());
      chk("mon_afull", almost_full, sb_q.size() >= AFULL);
      chk("mon_mvalid", m_valid, sb_q.size() != 0);
      chk("mon_sready", s_ready, sb_q.size() != DEPTH);
      if (flush) begin
        sb_q.delete();
      end else begin
        if (m_valid && m_ready) begin
          n_pop++;
          if (sb_q.size() == 0) chk("mon_pop_empty", {m_last, m_data}, '1);
          else chk("mon_data", {m_last, m_data}, sb_q.pop_front());
        end
        if (s_valid && s_ready) begin
          n_push++;
          sb_q.push_back({s_last, s_data});
        end
      end
    end
  end

  initial begin
    int base;
    int cyc;
    bit seen;

    // ---- reset state
    #2;
    chk("rst_level", level, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_mdata", {m_last, m_data}, 0);
    chk("rst_sready", s_ready, 0);
    chk("rst_afull", almost_full, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("sready_before_edge", s_ready, 0);
    step();
    chk("sready_after_edge", s_ready, 1);
    mon_en = 1'b1;

    // ---- single beat
    s_valid = 1'b1; s_data = 64'hA5; s_last = 1'b1;
    step();
    s_valid = 1'b0;
    chk("single_mvalid", m_valid, 1);
    chk("single_data", {m_last, m_data}, {1'b1, 64'hA5});
    chk("single_level1", level, 1);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("single_level0", level, 0);
    chk("single_mvalid_low", m_valid, 0);
    chk("empty_hold", {m_last, m_data}, {1'b1, 64'hA5});

    // ---- fill and backpressure
    base = n_pop;
    s_valid = 1'b1; s_data = 1; s_last = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      int lv;
      step();
      lv = (i < DEPTH) ? i : DEPTH;
      chk("fill_level", level, lv);
      chk("fill_afull", almost_full, lv >= AFULL);
      chk("fill_sready", s_ready, lv < DEPTH);
      if (i < 5) begin
        s_data = i + 1;
        s_last = (i + 1 == 5);
      end
    end
    m_ready = 1'b1;
    step();
    chk("release_level", level, 3);
    chk("release_sready", s_ready, 1);
    step();
    s_valid = 1'b0;
    chk("refill_level", level, 3);
    for (int j = 0; j < 3; j++) begin
      chk("drain_mvalid", m_valid, 1);
      step();
    end
    chk("drain_level", level, 0);
    chk("drain_count", n_pop - base, 5);

    // ---- streaming
    base = n_pop;
    s_valid = 1'b1; s_last = 1'b0;
    for (int i = 0; i < 100; i++) begin
      s_data = 64'h1000 + i;
      step();
      chk("stream_level", level, 1);
      chk("stream_mvalid", m_valid, 1);
    end
    s_valid = 1'b0;
    step();
    chk("stream_end_level", level, 0);
    chk("stream_count", n_pop - base, 100);

    // ---- flush with same-edge accept and pop
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 64'hF00 + i;
      step();
    end
    chk("pre_flush_level", level, 3);
    s_data = 64'hDEAD; m_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; s_valid = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_mvalid", m_valid, 0);
    chk("flush_sready", s_ready, 1);
    s_valid = 1'b1; s_data = 64'h77; s_last = 1'b1;
    step();
    s_valid = 1'b0;
    chk("post_flush_data", {m_last, m_data}, {1'b1, 64'h77});
    step();
    chk("post_flush_level", level, 0);

    // ---- random traffic
    base = n_push;
    cyc = 0;
    while ((n_push - base) < 10000 && cyc < 60000) begin
      s_valid = ($urandom_range(0, 1) == 1);
      m_ready = ($urandom_range(0, 1) == 1);
      s_data  = {$urandom, $urandom};
      s_last  = ($urandom_range(0, 7) == 0);
      step();
      cyc++;
    end
    chk("rand_count_reached", (n_push - base) >= 10000, 1);
    s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("rand_drain_level", level, 0);
    chk("rand_sb_empty", sb_q.size(), 0);

    // ---- asynchronous reset mid-stream
    m_ready = 1'b0; s_valid = 1'b1; s_last = 1'b0;
    s_data = 64'hBAD0; step();
    s_data = 64'hBAD1; step();
    s_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    mon_en = 1'b0;
    chk("arst_mvalid", m_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_sready", s_ready, 0);
    chk("arst_mdata", {m_last, m_data}, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
    chk("arst_sready_up", s_ready, 1);
    mon_en = 1'b1;
    s_valid = 1'b1; s_data = 64'h1234; s_last = 1'b1; m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (m_valid) begin
        seen = 1'b1;
        chk("arst_first_out", {m_last, m_data}, {1'b1, 64'h1234});
      end else begin
        step();
      end
    end
    chk("arst_out_seen", seen, 1);
    step();
    chk("arst_final_level", level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
